// File: rtl/alu_prog_seq_if.sv
// Bus bundle between the ALU program sequencer and its environment
// (program ROM, operand RAMs A/B, result RAM C, ALU opcode, run handshake).
//
// Signals (master = sequencer side):
//   start      in   run request
//   busy       out  run in progress
//   done       out  one-cycle end-of-program pulse
//   err        out  sticky bad jump/loop target flag
//   rom_addr   out  program counter
//   rom_rd     out  ROM read enable
//   rom_data   in   ROM word, valid one cycle after rom_rd
//   mem_a_rd   out  operand A read enable
//   mem_a_addr out  operand A address
//   mem_b_rd   out  operand B read enable
//   mem_b_addr out  operand B address
//   mem_c_wr   out  result write enable
//   mem_c_addr out  result address
//   ops        out  ALU operation code
//   exec_cnt   out  EXEC instructions completed in the current run
interface alu_prog_seq_if #(
  parameter int INSTR_W = 32,
  parameter int OP_W    = 8,
  parameter int ADDR_W  = 5,
  parameter int PC_W    = 5,
  parameter int CNT_W   = 16
);

  logic               start;
  logic               busy;
  logic               done;
  logic               err;
  logic [PC_W-1:0]    rom_addr;
  logic               rom_rd;
  logic [INSTR_W-1:0] rom_data;
  logic               mem_a_rd;
  logic [ADDR_W-1:0]  mem_a_addr;
  logic               mem_b_rd;
  logic [ADDR_W-1:0]  mem_b_addr;
  logic               mem_c_wr;
  logic [ADDR_W-1:0]  mem_c_addr;
  logic [OP_W-1:0]    ops;
  logic [CNT_W-1:0]   exec_cnt;

  modport master (
    input  start, rom_data,
    output busy, done, err, rom_addr, rom_rd,
           mem_a_rd, mem_a_addr, mem_b_rd, mem_b_addr,
           mem_c_wr, mem_c_addr, ops, exec_cnt
  );

  modport slave (
    output start, rom_data,
    input  busy, done, err, rom_addr, rom_rd,
           mem_a_rd, mem_a_addr, mem_b_rd, mem_b_addr,
           mem_c_wr, mem_c_addr, ops, exec_cnt
  );

endinterface

// File: rtl/alu_prog_seq.sv
// Program sequencer for the ALU datapath. Fetches instruction words from
// the program ROM, issues operand reads to RAM A/B, drives the ALU opcode
// for ALU_LAT+1 cycles and then strobes the result write into RAM C.
// Supports HALT, JUMP and a single-level LOOP (body runs N+1 times), a
// sticky error flag for out-of-range targets and an EXEC counter.
//
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  alu_prog_seq_if master modport (handshake, ROM, RAM A/B/C, ops)
//
// Instruction word: op = [OP_W-1:0], then srcA, srcB, dst (ADDR_W each),
// kind = [INSTR_W-1:INSTR_W-2] (00 EXEC, 01 HALT, 10 JUMP, 11 LOOP).
// Interface parameters must match the module parameters.
module alu_prog_seq #(
  parameter int INSTR_W  = 32,
  parameter int OP_W     = 8,
  parameter int ADDR_W   = 5,
  parameter int PC_W     = 5,
  parameter int PROG_LEN = 32,
  parameter int ALU_LAT  = 0,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  alu_prog_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_EXEC = 2'b00,
    K_HALT = 2'b01,
    K_JUMP = 2'b10,
    K_LOOP = 2'b11
  } kind_t;

  localparam int            FIELD_TOP = OP_W + 3 * ADDR_W;
  localparam logic [2:0]    LAT_LAST  = 3'(ALU_LAT);
  localparam logic [PC_W:0] LEN_C     = (PC_W + 1)'(PROG_LEN);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   srca_q, srca_d;
  logic [ADDR_W-1:0]   srcb_q, srcb_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [2:0]          lat_q, lat_d;
  logic                loop_active_q, loop_active_d;
  logic [ADDR_W-1:0]   loop_cnt_q, loop_cnt_d;
  logic [CNT_W-1:0]    exec_cnt_q, exec_cnt_d;
  logic                err_q, err_d;

  // Instruction fields straight off the ROM output, used in DECODE.
  logic [OP_W-1:0]     f_op;
  logic [ADDR_W-1:0]   f_srca;
  logic [ADDR_W-1:0]   f_srcb;
  logic [ADDR_W-1:0]   f_dst;
  kind_t               f_kind;
  logic [PC_W-1:0]     f_target;
  logic                target_bad;
  logic                pc_last;
  logic                jump_req;
  logic                fall_req;

  assign f_op       = bus.rom_data[OP_W-1:0];
  assign f_srca     = bus.rom_data[OP_W +: ADDR_W];
  assign f_srcb     = bus.rom_data[OP_W + ADDR_W +: ADDR_W];
  assign f_dst      = bus.rom_data[OP_W + 2 * ADDR_W +: ADDR_W];
  assign f_kind     = kind_t'(bus.rom_data[INSTR_W-1 -: 2]);
  assign f_target   = f_dst[PC_W-1:0];
  assign target_bad = {1'b0, f_target} >= LEN_C;
  assign pc_last    = (pc_q == PC_LAST);

  generate
    if (INSTR_W - 2 > FIELD_TOP) begin : g_spare
      logic unused_spare_bits;
      assign unused_spare_bits = ^bus.rom_data[INSTR_W-3:FIELD_TOP];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      op_q          <= '0;
      srca_q        <= '0;
      srcb_q        <= '0;
      dst_q         <= '0;
      lat_q         <= '0;
      loop_active_q <= 1'b0;
      loop_cnt_q    <= '0;
      exec_cnt_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      op_q          <= op_d;
      srca_q        <= srca_d;
      srcb_q        <= srcb_d;
      dst_q         <= dst_d;
      lat_q         <= lat_d;
      loop_active_q <= loop_active_d;
      loop_cnt_q    <= loop_cnt_d;
      exec_cnt_q    <= exec_cnt_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    op_d          = op_q;
    srca_d        = srca_q;
    srcb_d        = srcb_q;
    dst_d         = dst_q;
    lat_d         = lat_q;
    loop_active_d = loop_active_q;
    loop_cnt_d    = loop_cnt_q;
    exec_cnt_d    = exec_cnt_q;
    err_d         = err_q;
    jump_req      = 1'b0;
    fall_req      = 1'b0;

    bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    bus.done       = 1'b0;
    bus.rom_rd     = 1'b0;
    bus.rom_addr   = (state_q == S_IDLE) ? '0 : pc_q;
    bus.mem_a_rd   = 1'b0;
    bus.mem_a_addr = '0;
    bus.mem_b_rd   = 1'b0;
    bus.mem_b_addr = '0;
    bus.mem_c_wr   = 1'b0;
    bus.mem_c_addr = '0;
    bus.ops        = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_d          = '0;
          exec_cnt_d    = '0;
          err_d         = 1'b0;
          loop_active_d = 1'b0;
          state_d       = S_FETCH;
        end
      end

      S_FETCH: begin
        bus.rom_rd = 1'b1;
        state_d    = S_DECODE;
      end

      S_DECODE: begin
        op_d   = f_op;
        srca_d = f_srca;
        srcb_d = f_srcb;
        dst_d  = f_dst;
        case (f_kind)
          K_EXEC: state_d = S_READ;
          K_HALT: state_d = S_DONE;
          K_JUMP: jump_req = 1'b1;
          K_LOOP: begin
            // srcB carries the repeat count N; the first pass arms the
            // counter, later passes count it down to the exit pass.
            if (!loop_active_q) begin
              if (f_srcb == '0) begin
                fall_req = 1'b1;
              end else begin
                loop_cnt_d    = f_srcb;
                loop_active_d = 1'b1;
                jump_req      = 1'b1;
              end
            end else if (loop_cnt_q == ADDR_W'(1)) begin
              loop_active_d = 1'b0;
              fall_req      = 1'b1;
            end else begin
              loop_cnt_d = loop_cnt_q - ADDR_W'(1);
              jump_req   = 1'b1;
            end
          end
          default: state_d = S_DONE;
        endcase

        if (jump_req) begin
          if (target_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d    = f_target;
            state_d = S_FETCH;
          end
        end else if (fall_req) begin
          if (pc_last) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
        end
      end

      S_READ: begin
        bus.mem_a_rd   = 1'b1;
        bus.mem_b_rd   = 1'b1;
        bus.mem_a_addr = srca_q;
        bus.mem_b_addr = srcb_q;
        lat_d          = '0;
        state_d        = S_EXEC;
      end

      S_EXEC: begin
        bus.ops = op_q;
        if (lat_q == LAT_LAST) begin
          state_d = S_WRITE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      S_WRITE: begin
        bus.ops        = op_q;
        bus.mem_c_wr   = 1'b1;
        bus.mem_c_addr = dst_q;
        exec_cnt_d     = exec_cnt_q + CNT_W'(1);
        if (pc_last) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end

      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.err      = err_q;
  assign bus.exec_cnt = exec_cnt_q;

endmodule

// File: tb/tb_alu_prog_seq.sv
// Scoreboard bench for alu_prog_seq: three instances (ALU_LAT=0/PROG_LEN=8,
// ALU_LAT=3/PROG_LEN=8, ALU_LAT=0/PROG_LEN=2) with directed programs.
// Stimulus pushes expected write/done events; a negedge monitor pops and
// compares whenever a DUT shows mem_c_wr or done.
module tb_alu_prog_seq;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_r [NI];
  logic [31:0] rom     [NI][32];

  logic        busy_w [NI];
  logic        done_w [NI];
  logic        err_w  [NI];
  logic        rrd_w  [NI];
  logic        ard_w  [NI];
  logic        brd_w  [NI];
  logic        cwr_w  [NI];
  logic [4:0]  raddr_w[NI];
  logic [4:0]  aaddr_w[NI];
  logic [4:0]  baddr_w[NI];
  logic [4:0]  caddr_w[NI];
  logic [7:0]  ops_w  [NI];
  logic [15:0] cnt_w  [NI];

  typedef struct {
    bit         is_done;
    int         rel;
    logic [4:0] addr;
    logic [7:0] ops;
    int         run;
    int         cnt;
    bit         err;
  } ev_t;

  ev_t expq[NI][$];
  int  st_cyc [NI];
  int  run_len[NI];
  int  checks = 0;
  int  errors = 0;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int LAT = (g == 1) ? 3 : 0;
      localparam int LEN = (g == 2) ? 2 : 8;

      alu_prog_seq_if #(.INSTR_W(32), .OP_W(8), .ADDR_W(5), .PC_W(5), .CNT_W(16)) bus ();

      logic [31:0] q;
      always @(posedge clk) if (bus.rom_rd) q <= rom[g][bus.rom_addr];

      assign bus.rom_data = q;
      assign bus.start    = start_r[g];
      assign busy_w[g]    = bus.busy;
      assign done_w[g]    = bus.done;
      assign err_w[g]     = bus.err;
      assign rrd_w[g]     = bus.rom_rd;
      assign ard_w[g]     = bus.mem_a_rd;
      assign brd_w[g]     = bus.mem_b_rd;
      assign cwr_w[g]     = bus.mem_c_wr;
      assign raddr_w[g]   = bus.rom_addr;
      assign aaddr_w[g]   = bus.mem_a_addr;
      assign baddr_w[g]   = bus.mem_b_addr;
      assign caddr_w[g]   = bus.mem_c_addr;
      assign ops_w[g]     = bus.ops;
      assign cnt_w[g]     = bus.exec_cnt;

      alu_prog_seq #(
        .INSTR_W (32),
        .OP_W    (8),
        .ADDR_W  (5),
        .PC_W    (5),
        .PROG_LEN(LEN),
        .ALU_LAT (LAT),
        .CNT_W   (16)
      ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
      );
    end
  endgenerate

  task automatic chk(input string nm, input int inst, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0d expected=%0d t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  // Monitor: consumes one expected event per observed write or done cycle.
  always @(negedge clk) begin : mon
    ev_t e;
    for (int i = 0; i < NI; i++) begin
      if (ops_w[i] != 8'd0) run_len[i] = run_len[i] + 1;
      else                  run_len[i] = 0;
      if (cwr_w[i] || done_w[i]) begin
        if (expq[i].size() == 0) begin
          chk("unexpected_event", i, {cwr_w[i], done_w[i]}, 0);
        end else begin
          e = expq[i].pop_front();
          chk("event_kind", i, done_w[i], e.is_done);
          chk("event_cycle", i, cyc - st_cyc[i], e.rel);
          if (!e.is_done) begin
            chk("wr_addr", i, caddr_w[i], e.addr);
            chk("wr_ops", i, ops_w[i], e.ops);
            chk("ops_stable_cycles", i, run_len[i], e.run);
          end else begin
            chk("done_exec_cnt", i, cnt_w[i], e.cnt);
            chk("done_err", i, err_w[i], e.err);
            chk("done_busy", i, busy_w[i], 0);
            chk("done_ops", i, ops_w[i], 0);
          end
        end
      end
    end
  end

  function automatic logic [31:0] mk(input int kind, input int op, input int a, input int b, input int c);
    return {kind[1:0], 7'b0, c[4:0], b[4:0], a[4:0], op[7:0]};
  endfunction

  task automatic push_wr(input int i, input int rel, input int addr, input int op, input int run);
    ev_t e;
    e.is_done = 1'b0; e.rel = rel; e.addr = addr[4:0]; e.ops = op[7:0];
    e.run = run; e.cnt = 0; e.err = 1'b0;
    expq[i].push_back(e);
  endtask

  task automatic push_done(input int i, input int rel, input int cnt, input bit er);
    ev_t e;
    e.is_done = 1'b1; e.rel = rel; e.addr = '0; e.ops = '0;
    e.run = 0; e.cnt = cnt; e.err = er;
    expq[i].push_back(e);
  endtask

  task automatic clear_rom(input int i);
    for (int k = 0; k < 32; k++) rom[i][k] = mk(1, 0, 0, 0, 0);
  endtask

  task automatic start_inst(input int i);
    @(negedge clk);
    start_r[i] = 1'b1;
    st_cyc[i]  = cyc;
    @(negedge clk);
    start_r[i] = 1'b0;
  endtask

  task automatic wait_rel(input int i, input int r);
    for (int k = 0; k < 200 && (cyc - st_cyc[i]) < r; k++) @(negedge clk);
  endtask

  task automatic wait_drain(input int i, input int bound);
    for (int k = 0; k < bound && expq[i].size() != 0; k++) @(negedge clk);
    chk("pending_events", i, expq[i].size(), 0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog simulation did not complete t=%0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start_r[i] = 1'b1;
      clear_rom(i);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk("reset_outputs", i,
          {busy_w[i], done_w[i], err_w[i], rrd_w[i], ard_w[i], brd_w[i], cwr_w[i],
           raddr_w[i], aaddr_w[i], baddr_w[i], caddr_w[i], ops_w[i], cnt_w[i]}, 0);
    for (int i = 0; i < NI; i++) start_r[i] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) chk("idle_after_reset_busy", i, busy_w[i], 0);

    // Single EXEC then HALT, ALU_LAT=0.
    rom[0][0] = mk(0, 3, 1, 2, 4);
    rom[0][1] = mk(1, 0, 0, 0, 0);
    push_wr(0, 5, 4, 3, 2);
    push_done(0, 8, 1, 0);
    start_inst(0);
    wait_drain(0, 40);

    // Same program, ALU_LAT=3.
    rom[1][0] = mk(0, 3, 1, 2, 4);
    rom[1][1] = mk(1, 0, 0, 0, 0);
    push_wr(1, 8, 4, 3, 5);
    push_done(1, 11, 1, 0);
    start_inst(1);
    wait_drain(1, 40);

    // Two EXECs inside a LOOP N=2 back to 0: body runs three times.
    clear_rom(0);
    rom[0][0] = mk(0, 'h11, 1, 2, 5);
    rom[0][1] = mk(0, 'h22, 3, 4, 6);
    rom[0][2] = mk(3, 0, 0, 2, 0);
    rom[0][3] = mk(1, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      push_wr(0, 5 + 12 * p, 5, 'h11, 2);
      push_wr(0, 10 + 12 * p, 6, 'h22, 2);
    end
    push_done(0, 39, 6, 0);
    start_inst(0);
    wait_drain(0, 80);

    // JUMP to 31 with PROG_LEN=8: error, done, no further fetch.
    clear_rom(0);
    rom[0][0] = mk(2, 0, 0, 0, 31);
    push_done(0, 3, 0, 1);
    start_inst(0);
    wait_drain(0, 20);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (rrd_w[0]) n++;
    end
    chk("no_fetch_after_err", 0, n, 0);
    chk("err_sticky", 0, err_w[0], 1);

    // Valid JUMP over an EXEC to a HALT; err clears on this start.
    clear_rom(0);
    rom[0][0] = mk(2, 0, 0, 0, 2);
    rom[0][1] = mk(0, 9, 0, 0, 0);
    push_done(0, 5, 0, 0);
    start_inst(0);
    wait_drain(0, 20);

    // PROG_LEN=2, two EXECs, implicit end; start pulses mid-run and in DONE.
    rom[2][0] = mk(0, 5, 7, 8, 9);
    rom[2][1] = mk(0, 6, 10, 11, 12);
    push_wr(2, 5, 9, 5, 2);
    push_wr(2, 10, 12, 6, 2);
    push_done(2, 11, 2, 0);
    start_inst(2);
    wait_rel(2, 3);
    start_r[2] = 1'b1;
    @(negedge clk);
    start_r[2] = 1'b0;
    wait_rel(2, 11);
    start_r[2] = 1'b1;
    @(negedge clk);
    start_r[2] = 1'b0;
    chk("start_in_done_ignored_busy", 2, busy_w[2], 0);
    @(negedge clk);
    chk("start_in_done_ignored_fetch", 2, rrd_w[2], 0);
    wait_drain(2, 20);

    // Reset while the second EXEC is in its EXEC state.
    push_wr(2, 5, 9, 5, 2);
    start_inst(2);
    wait_rel(2, 9);
    chk("cnt_before_reset", 2, cnt_w[2], 1);
    #1 rst = 1'b0;
    #1;
    chk("reset_mid_busy", 2, busy_w[2], 0);
    chk("reset_mid_wr", 2, cwr_w[2], 0);
    chk("reset_mid_cnt", 2, cnt_w[2], 0);
    chk("reset_mid_ops", 2, ops_w[2], 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_reset_busy", 2, busy_w[2], 0);
    chk("after_reset_events", 2, expq[2].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
